// File: rtl/dcmac_rx_port_arbiter_if.sv
// AXI-stream style beat bus for one 2-segment DCMAC RX stream.
// Used for both arbiter inputs and the merged output.
interface dcmac_rx_port_arbiter_if #(
    parameter int SEG_W = 128
);
    logic [2*SEG_W-1:0] tdata;
    logic [5:0]         tuser;
    logic               tlast;
    logic               tvalid;
    logic               tready;

    modport master (output tdata, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/dcmac_rx_port_arbiter.sv
// Packet-granular round-robin merge of two DCMAC RX ports; optional counters under DCMAC_RX_ARB_STATS_EN.
// 0-cycle combinational datapath (1 bubble from IDLE); grant held until tlast; tready mirrors out tready.
module dcmac_rx_port_arbiter #(
    parameter int SEG_W = 128,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    dcmac_rx_port_arbiter_if.slave     in0,
    dcmac_rx_port_arbiter_if.slave     in1,
    dcmac_rx_port_arbiter_if.master    out,
    output logic                       out_tid,
    input  logic                       stats_clear,
    output logic [CNT_W-1:0]           pkt_count0,
    output logic [CNT_W-1:0]           pkt_count1
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;

    logic [2*SEG_W-1:0] mux_dat;
    logic [5:0]         mux_user;
    logic               mux_last;
    logic               mux_vld;
    logic               mux_tid;
    logic               rdy0;
    logic               rdy1;
    logic               eop0;
    logic               eop1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mux_dat      = '0;
        mux_user     = '0;
        mux_last     = 1'b0;
        mux_vld      = 1'b0;
        mux_tid      = 1'b0;
        rdy0         = 1'b0;
        rdy1         = 1'b0;
        eop0         = 1'b0;
        eop1         = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time goes next.
                if (in0.tvalid && in1.tvalid)
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                else if (in0.tvalid)
                    state_d = GRANT0;
                else if (in1.tvalid)
                    state_d = GRANT1;
            end
            GRANT0: begin
                mux_dat  = in0.tdata;
                mux_user = in0.tuser;
                mux_last = in0.tlast;
                mux_vld  = in0.tvalid;
                mux_tid  = 1'b0;
                rdy0     = out.tready;
                eop0     = in0.tvalid && out.tready && in0.tlast;
                if (eop0)
                    state_d = in1.tvalid ? GRANT1 : IDLE;
            end
            GRANT1: begin
                mux_dat  = in1.tdata;
                mux_user = in1.tuser;
                mux_last = in1.tlast;
                mux_vld  = in1.tvalid;
                mux_tid  = 1'b1;
                rdy1     = out.tready;
                eop1     = in1.tvalid && out.tready && in1.tlast;
                if (eop1)
                    state_d = in0.tvalid ? GRANT0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == GRANT0)
            last_grant_d = 1'b0;
        else if (state_d == GRANT1)
            last_grant_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out.tdata  = mux_dat;
    assign out.tuser  = mux_user;
    assign out.tlast  = mux_last;
    assign out.tvalid = mux_vld;
    assign out_tid    = mux_tid;
    assign in0.tready = rdy0;
    assign in1.tready = rdy1;

`ifdef DCMAC_RX_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Clear takes priority over a same-cycle packet end.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (stats_clear) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (eop0) cnt0_d = cnt0_q + 1'b1;
            if (eop1) cnt1_d = cnt1_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign pkt_count0 = cnt0_q;
    assign pkt_count1 = cnt1_q;
`else
    logic unused_stats;
    assign unused_stats = stats_clear ^ eop0 ^ eop1;
    assign pkt_count0   = '0;
    assign pkt_count1   = '0;
`endif
endmodule

// File: tb/tb_dcmac_rx_port_arbiter.sv
// Directed bench for dcmac_rx_port_arbiter: grant, rotation, hold, backpressure, reset, stats.
module tb_dcmac_rx_port_arbiter;
    localparam int SEG_W = 16;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             out_tid;
    logic             stats_clear;
    logic [CNT_W-1:0] pkt_count0;
    logic [CNT_W-1:0] pkt_count1;

    dcmac_rx_port_arbiter_if #(.SEG_W(SEG_W)) in0_if ();
    dcmac_rx_port_arbiter_if #(.SEG_W(SEG_W)) in1_if ();
    dcmac_rx_port_arbiter_if #(.SEG_W(SEG_W)) out_if ();

    dcmac_rx_port_arbiter #(.SEG_W(SEG_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in0         (in0_if),
        .in1         (in1_if),
        .out         (out_if),
        .out_tid     (out_tid),
        .stats_clear (stats_clear),
        .pkt_count0  (pkt_count0),
        .pkt_count1  (pkt_count1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_tid [6] = '{0, 0, 1, 1, 0, 0};
    int exp_dat [6] = '{32'h0A00, 32'h0A01, 32'h0B00, 32'h0B01, 32'h0A02, 32'h0A03};
    int p0;
    int p1;
    int t;
    int exp_cnt0;
    int exp_cnt1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input int p, input logic v, input logic [31:0] d,
                       input logic [5:0] u, input logic l);
        if (p == 0) begin
            in0_if.tvalid = v; in0_if.tdata = d; in0_if.tuser = u; in0_if.tlast = l;
        end else begin
            in1_if.tvalid = v; in1_if.tdata = d; in1_if.tuser = u; in1_if.tlast = l;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        drv(0, 1'b0, 32'h0, 6'h0, 1'b0);
        drv(1, 1'b0, 32'h0, 6'h0, 1'b0);
        out_if.tready = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic send_pkt(input int p, input int nbeats, input logic [31:0] base);
        int b = 0;
        int tt = 0;
        while (b < nbeats && tt < 50) begin
            @(posedge clk); #1;
            drv(p, 1'b1, base + b, 6'h04, b == nbeats - 1);
            @(negedge clk);
            if ((p == 0) ? in0_if.tready : in1_if.tready) b++;
            tt++;
        end
        @(posedge clk); #1;
        drv(p, 1'b0, 32'h0, 6'h0, 1'b0);
        chk("pkt_done", b, nbeats);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        stats_clear   = 1'b0;
        out_if.tready = 1'b1;
        drv(0, 1'b0, 32'h0, 6'h0, 1'b0);
        drv(1, 1'b0, 32'h0, 6'h0, 1'b0);
        #12;
        chk("rst_out_vld", 32'(out_if.tvalid), 0);
        chk("rst_rdy0", 32'(in0_if.tready), 0);
        chk("rst_rdy1", 32'(in1_if.tready), 0);
        chk("rst_cnt0", pkt_count0, 0);
        chk("rst_cnt1", pkt_count1, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // single 3-beat packet from port 0
        @(posedge clk); #1; drv(0, 1'b1, 32'h100, 6'h06, 1'b0);
        @(negedge clk);
        chk("t1_bubble_vld", 32'(out_if.tvalid), 0);
        chk("t1_bubble_rdy0", 32'(in0_if.tready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_b0_vld", 32'(out_if.tvalid), 1);
        chk("t1_b0_dat", out_if.tdata, 32'h100);
        chk("t1_b0_user", 32'(out_if.tuser), 32'h06);
        chk("t1_b0_tid", 32'(out_tid), 0);
        chk("t1_b0_rdy0", 32'(in0_if.tready), 1);
        chk("t1_b0_rdy1", 32'(in1_if.tready), 0);
        @(posedge clk); #1; drv(0, 1'b1, 32'h101, 6'h04, 1'b0);
        @(negedge clk);
        chk("t1_b1_dat", out_if.tdata, 32'h101);
        chk("t1_b1_last", 32'(out_if.tlast), 0);
        chk("t1_b1_rdy1", 32'(in1_if.tready), 0);
        @(posedge clk); #1; drv(0, 1'b1, 32'h102, 6'h05, 1'b1);
        @(negedge clk);
        chk("t1_b2_dat", out_if.tdata, 32'h102);
        chk("t1_b2_last", 32'(out_if.tlast), 1);
        chk("t1_b2_err", 32'(out_if.tuser), 32'h05);
        chk("t1_b2_tid", 32'(out_tid), 0);
        chk("t1_b2_rdy1", 32'(in1_if.tready), 0);
        @(posedge clk); #1; drv(0, 1'b0, 32'h0, 6'h0, 1'b0);
        @(negedge clk);
        chk("t1_end_vld", 32'(out_if.tvalid), 0);

        // both ports continuously valid, 2-beat packets
        do_reset();
        p0 = 0; p1 = 0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            drv(0, 1'b1, 32'h0A00 + p0, 6'h04, p0[0]);
            drv(1, 1'b1, 32'h0B00 + p1, 6'h04, p1[0]);
            @(negedge clk);
            if (c == 0) begin
                chk("t2_bubble", 32'(out_if.tvalid), 0);
            end else begin
                chk("t2_vld", 32'(out_if.tvalid), 1);
                chk("t2_tid", 32'(out_tid), exp_tid[c-1]);
                chk("t2_dat", out_if.tdata, exp_dat[c-1]);
            end
            if (in0_if.tready) p0++;
            if (in1_if.tready) p1++;
        end

        // port 1 stalls mid-packet while port 0 waits
        do_reset();
        @(posedge clk); #1; drv(1, 1'b1, 32'h300, 6'h04, 1'b0);
        @(negedge clk);
        chk("t3_bubble", 32'(out_if.tvalid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_b0_tid", 32'(out_tid), 1);
        chk("t3_b0_dat", out_if.tdata, 32'h300);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drv(1, 1'b0, 32'h0, 6'h0, 1'b0);
            drv(0, 1'b1, 32'h310, 6'h04, 1'b1);
            @(negedge clk);
            chk("t3_gap_vld", 32'(out_if.tvalid), 0);
            chk("t3_gap_rdy0", 32'(in0_if.tready), 0);
            chk("t3_gap_tid", 32'(out_tid), 1);
        end
        @(posedge clk); #1; drv(1, 1'b1, 32'h301, 6'h04, 1'b1);
        @(negedge clk);
        chk("t3_b1_tid", 32'(out_tid), 1);
        chk("t3_b1_dat", out_if.tdata, 32'h301);
        chk("t3_b1_last", 32'(out_if.tlast), 1);
        @(posedge clk); #1; drv(1, 1'b0, 32'h0, 6'h0, 1'b0);
        @(negedge clk);
        chk("t3_sw_vld", 32'(out_if.tvalid), 1);
        chk("t3_sw_tid", 32'(out_tid), 0);
        chk("t3_sw_dat", out_if.tdata, 32'h310);

        // out_tready toggling during a 4-beat packet
        do_reset();
        @(posedge clk); #1; drv(0, 1'b1, 32'h400, 6'h04, 1'b0);
        @(negedge clk);
        p0 = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            out_if.tready = (i % 2 == 0);
            if (p0 < 4) drv(0, 1'b1, 32'h400 + p0, 6'h04, p0 == 3);
            else        drv(0, 1'b0, 32'h0, 6'h0, 1'b0);
            @(negedge clk);
            chk("t4_rdy_mirror", 32'(in0_if.tready), 32'(out_if.tready));
            if (out_if.tvalid && out_if.tready) begin
                chk("t4_beat", out_if.tdata, 32'h400 + p0);
                p0++;
            end
        end
        chk("t4_nbeats", p0, 4);
        out_if.tready = 1'b1;

        // reset asserted on beat 2 of 4
        do_reset();
        @(posedge clk); #1; drv(0, 1'b1, 32'h500, 6'h04, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1; drv(0, 1'b1, 32'h501, 6'h04, 1'b0);
        @(negedge clk);
        chk("t5_b1_dat", out_if.tdata, 32'h501);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_vld", 32'(out_if.tvalid), 0);
        chk("t5_rst_rdy0", 32'(in0_if.tready), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        drv(0, 1'b1, 32'h520, 6'h04, 1'b1);
        drv(1, 1'b1, 32'h530, 6'h04, 1'b1);
        @(negedge clk);
        chk("t5_idle_vld", 32'(out_if.tvalid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_tid", 32'(out_tid), 0);
        chk("t5_dat", out_if.tdata, 32'h520);
        @(posedge clk); #1;
        drv(0, 1'b0, 32'h0, 6'h0, 1'b0);
        drv(1, 1'b0, 32'h0, 6'h0, 1'b0);

        // packet counters
        do_reset();
        for (int i = 0; i < 5; i++) send_pkt(0, 1 + (i % 2), 32'h600 + 16 * i);
        for (int i = 0; i < 3; i++) send_pkt(1, 2 - (i % 2), 32'h700 + 16 * i);
`ifdef DCMAC_RX_ARB_STATS_EN
        exp_cnt0 = 5; exp_cnt1 = 3;
`else
        exp_cnt0 = 0; exp_cnt1 = 0;
`endif
        chk("t6_cnt0", pkt_count0, exp_cnt0);
        chk("t6_cnt1", pkt_count1, exp_cnt1);
        @(posedge clk); #1; drv(0, 1'b1, 32'h680, 6'h04, 1'b1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in0_if.tready && t < 10);
        chk("t6_clr_hs", 32'(in0_if.tready), 1);
        stats_clear = 1'b1;
        @(posedge clk); #1;
        stats_clear = 1'b0;
        drv(0, 1'b0, 32'h0, 6'h0, 1'b0);
        chk("t6_clr_cnt0", pkt_count0, 0);
        chk("t6_clr_cnt1", pkt_count1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
